// File: rtl/uart_rx_bus_slave.sv
// uart_rx_bus_slave: 8N1 UART receiver with RX FIFO behind a 4-word bus slot (DATA/STATUS/CTRL/DIVISOR).
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data and stop bits.

package MemoryBus;
   typedef struct packed {
      logic        mem_read;
      logic [3:0]  mask_byte;
      logic [31:0] write_data;
   } Cmd;
   typedef struct packed {
      logic [31:0] read_data;
   } Result;
endpackage

module uart_rx_bus_slave #(
   parameter int FIFO_DEPTH  = 8,
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 868
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       bus_address,
   input  logic             write_enable,
   input  MemoryBus::Cmd    membuscmd,
   output MemoryBus::Result membusres,
   input  logic             rx,
   output logic             rx_irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

   state_t                 state, state_n;
   logic                   rx_meta, rx_sync;
   logic [DIV_WIDTH-1:0]   divisor, bit_div, cnt, div_new;
   logic [2:0]             idx;
   logic [7:0]             shift;
   logic [7:0]             mem [FIFO_DEPTH];
   logic [AW-1:0]          wp, rp;
   logic [CW-1:0]          count;
   logic                   rd_q, overrun, frame_err, parity_err, par_bad;
   logic                   tick, push_req, frame_set, pop, push_ok, full, not_empty, ovr_set;
   logic                   ctrl_we, div_we, flush;
   logic [31:0]            div_wr, data_word, stat_word;
   logic                   unused_bits;
`ifdef UART_RX_PARITY_EN
   logic                   par_set;
`endif

   assign tick        = cnt == '0;
   assign not_empty   = count != '0;
   assign full        = count == CW'(FIFO_DEPTH);
   assign ctrl_we     = write_enable && bus_address == 2'd2 && membuscmd.mask_byte[0];
   assign div_we      = write_enable && bus_address == 2'd3;
   assign flush       = ctrl_we && membuscmd.write_data[3];
   assign pop         = membuscmd.mem_read && bus_address == 2'd0 && !rd_q && not_empty;
   assign push_ok     = push_req && !flush && (!full || pop);
   assign ovr_set     = push_req && !flush && full && !pop;
   assign unused_bits = ^{membuscmd.write_data, div_wr};

   always_comb begin
      div_wr = 32'(divisor);
      for (int i = 0; i < 4; i++)
         if (membuscmd.mask_byte[i]) div_wr[8*i +: 8] = membuscmd.write_data[8*i +: 8];
   end

   assign div_new = div_wr[DIV_WIDTH-1:0] < DIV_WIDTH'(2) ? DIV_WIDTH'(2) : div_wr[DIV_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      push_req  = 1'b0;
      frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_set   = 1'b0;
`endif
      case (state)
         IDLE:    state_n = rx_sync ? IDLE : START;
         START:   state_n = !tick ? START : rx_sync ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
         DATA:    state_n = (tick && idx == 3'd7) ? PARITY : DATA;
         PARITY: begin
            state_n = tick ? STOP : PARITY;
            par_set = tick && (rx_sync != ^shift);
         end
`else
         DATA:    state_n = (tick && idx == 3'd7) ? STOP : DATA;
`endif
         STOP: begin
            state_n   = !tick ? STOP : rx_sync ? IDLE : BRK;
            push_req  = tick && rx_sync && !par_bad;
            frame_set = tick && !rx_sync;
         end
         // a low stop bit may be a break; wait for the line to return high
         BRK:     state_n = rx_sync ? IDLE : BRK;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         cnt     <= '0;
         bit_div <= DIV_WIDTH'(DEFAULT_DIV);
         idx     <= '0;
         shift   <= '0;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         if (state == IDLE && !rx_sync) begin
            bit_div <= divisor;
            cnt     <= divisor >> 1;
            idx     <= '0;
         end else cnt <= tick ? bit_div - DIV_WIDTH'(1) : cnt - DIV_WIDTH'(1);
         if (state == DATA && tick) begin
            shift <= {rx_sync, shift[7:1]};
            idx   <= idx + 3'd1;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         par_bad    <= state == IDLE ? 1'b0 : par_bad | par_set;
         parity_err <= par_set | (parity_err & ~(ctrl_we & membuscmd.write_data[2]));
      end
   end
`else
   assign par_bad    = 1'b0;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         divisor   <= DIV_WIDTH'(DEFAULT_DIV);
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         rd_q      <= 1'b0;
         rx_irq    <= 1'b0;
      end else begin
         rd_q      <= membuscmd.mem_read;
         rx_irq    <= not_empty;
         overrun   <= ovr_set | (overrun & ~(ctrl_we & membuscmd.write_data[0]));
         frame_err <= frame_set | (frame_err & ~(ctrl_we & membuscmd.write_data[1]));
         if (div_we) divisor <= div_new;
         if (flush) begin
            rp    <= wp;
            count <= '0;
         end else begin
            if (push_ok) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wp] <= shift;
   end

   assign data_word = {not_empty, 23'd0, not_empty ? mem[rp] : 8'd0};
   assign stat_word = {16'd0, 8'(count), 3'd0, parity_err, frame_err, overrun, full, not_empty};
   assign membusres.read_data = !membuscmd.mem_read ? 32'd0 :
                                bus_address == 2'd0 ? data_word :
                                bus_address == 2'd1 ? stat_word :
                                bus_address == 2'd3 ? 32'(divisor) : 32'd0;
endmodule

// File: tb/tb_uart_rx_bus_slave.sv
// tb_uart_rx_bus_slave: register-table vectors, timed corner sequences and random frames against a queue model.
module tb_uart_rx_bus_slave;
   localparam int DIV = 16;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   // negedges from driving the start bit until the edge that pushes the byte has passed
   localparam int PUSH_AT = 4 + DIV / 2 + DIV * (FRAME_BITS - 1);

   typedef struct {
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic [31:0] exp;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst, write_enable, rx, rx_irq;
   logic [1:0]       bus_address;
   MemoryBus::Cmd    membuscmd;
   MemoryBus::Result membusres;
   int               passed = 0, total = 0;
   logic [7:0]       q[$];
   logic             ovr = 1'b0, ferr = 1'b0, perr = 1'b0;
   vec_t             vecs[13];

   always #5 clk = ~clk;

   uart_rx_bus_slave dut (
      .clk(clk), .rst(rst), .bus_address(bus_address), .write_enable(write_enable),
      .membuscmd(membuscmd), .membusres(membusres), .rx(rx), .rx_irq(rx_irq)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   function automatic logic [31:0] status_model();
      return {16'd0, 8'(q.size()), 3'd0, perr, ferr, ovr, q.size() == 8, q.size() != 0};
   endfunction

   task automatic model_push(input logic [7:0] b);
      if (q.size() == 8) ovr = 1'b1;
      else q.push_back(b);
   endtask

   task automatic peek(input logic [1:0] a, output logic [31:0] d);
      bus_address = a;
      membuscmd.mem_read = 1'b1;
      #1 d = membusres.read_data;
      membuscmd.mem_read = 1'b0;
   endtask

   task automatic check_status(input string name);
      logic [31:0] d;
      peek(2'd1, d);
      check(name, d, status_model());
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] v, input logic [3:0] m);
      bus_address = a;
      membuscmd.write_data = v;
      membuscmd.mask_byte = m;
      write_enable = 1'b1;
      @(negedge clk);
      write_enable = 1'b0;
      membuscmd.mask_byte = 4'h0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit, input int low_extra);
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (DIV) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rx = par_bit;
      repeat (DIV) @(negedge clk);
`endif
      rx = stop_bit;
      repeat (DIV + (stop_bit ? 0 : low_extra)) @(negedge clk);
      rx = 1'b1;
      repeat (24) @(negedge clk);
   endtask

   task automatic drain(input string name);
      int hold;
      while (q.size() != 0) begin
         hold = $urandom_range(1, 3);
         bus_address = 2'd0;
         membuscmd.mem_read = 1'b1;
         #1 check(name, membusres.read_data, {1'b1, 23'd0, q[0]});
         void'(q.pop_front());
         for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            #1 check({name, " held"}, membusres.read_data, q.size() != 0 ? {1'b1, 23'd0, q[0]} : 32'd0);
         end
         @(negedge clk);
         membuscmd.mem_read = 1'b0;
         @(negedge clk);
      end
      membuscmd.mem_read = 1'b1;
      #1 check({name, " empty"}, membusres.read_data, 32'd0);
      @(negedge clk);
      membuscmd.mem_read = 1'b0;
      @(negedge clk);
      check({name, " irq low"}, rx_irq, 1'b0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [7:0]  b;
      logic        sb;
      int          k;
      vecs[0]  = '{1'b0, 2'd1, 32'h0,        4'h0, 32'h0};
      vecs[1]  = '{1'b0, 2'd0, 32'h0,        4'h0, 32'h0};
      vecs[2]  = '{1'b0, 2'd2, 32'h0,        4'h0, 32'h0};
      vecs[3]  = '{1'b0, 2'd3, 32'h0,        4'h0, 32'd868};
      vecs[4]  = '{1'b1, 2'd3, 32'h1,        4'hF, 32'h2};
      vecs[5]  = '{1'b1, 2'd3, 32'h0,        4'hF, 32'h2};
      vecs[6]  = '{1'b1, 2'd3, 32'h1234,     4'h1, 32'h34};
      vecs[7]  = '{1'b1, 2'd3, 32'h5600,     4'h2, 32'h5634};
      vecs[8]  = '{1'b1, 2'd3, 32'hFFFF0000, 4'hC, 32'h5634};
      vecs[9]  = '{1'b1, 2'd2, 32'hF,        4'h1, 32'h0};
      vecs[10] = '{1'b1, 2'd0, 32'hFF,       4'hF, 32'h0};
      vecs[11] = '{1'b1, 2'd1, 32'hFF,       4'hF, 32'h0};
      vecs[12] = '{1'b1, 2'd3, 32'd16,       4'hF, 32'd16};
      rst = 1'b1;
      rx = 1'b1;
      write_enable = 1'b0;
      bus_address = 2'd0;
      membuscmd = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset irq", rx_irq, 1'b0);
      check("idle bus", membusres.read_data, 32'h0);
      for (int i = 0; i < 13; i++) begin
         if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].mask);
         peek(vecs[i].addr, d);
         check($sformatf("vec%0d", i), d, vecs[i].exp);
      end

      fork
         send_frame(8'h55, 1'b1, ^8'h55, 0);
         begin
            repeat (80) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      join
      repeat (500) @(negedge clk);
      check_status("midframe reset");
      bus_write(2'd3, 32'd16, 4'hF);

      fork
         send_frame(8'hA5, 1'b1, ^8'hA5, 0);
         begin
            repeat (PUSH_AT - 1) @(negedge clk);
            check_status("before push");
            @(negedge clk);
            q.push_back(8'hA5);
            check_status("A5 status");
            check("irq lag", rx_irq, 1'b0);
            @(negedge clk);
            check("irq set", rx_irq, 1'b1);
         end
      join
      bus_address = 2'd0;
      membuscmd.mem_read = 1'b1;
      #1 check("A5 data", membusres.read_data, 32'h800000A5);
      void'(q.pop_front());
      @(negedge clk);
      #1 check("A5 held2", membusres.read_data, 32'h0);
      @(negedge clk);
      #1 check("A5 held3", membusres.read_data, 32'h0);
      @(negedge clk);
      membuscmd.mem_read = 1'b0;
      @(negedge clk);
      check_status("A5 popped");
      drain("A5 next");

      for (int j = 1; j <= 9; j++) begin
         send_frame(8'(j), 1'b1, ^8'(j), 0);
         model_push(8'(j));
      end
      check_status("overrun status");
      drain("overrun data");
      bus_write(2'd2, 32'h1, 4'h1);
      ovr = 1'b0;
      check_status("overrun clear");

      send_frame(8'h3C, 1'b0, ^8'h3C, 3 * DIV);
      ferr = 1'b1;
      check_status("frame err");
      bus_write(2'd2, 32'h2, 4'h1);
      ferr = 1'b0;
      check_status("frame clear");
      rx = 1'b0;
      repeat (8) @(negedge clk);
      rx = 1'b1;
      repeat (100) @(negedge clk);
      check_status("glitch");

      for (int j = 0; j < 8; j++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1, ^b, 0);
         model_push(b);
      end
      check_status("full");
      b = 8'($urandom);
      fork
         send_frame(b, 1'b1, ^b, 0);
         begin
            repeat (PUSH_AT - 1) @(negedge clk);
            bus_address = 2'd0;
            membuscmd.mem_read = 1'b1;
            #1 check("pushpop head", membusres.read_data, {1'b1, 23'd0, q[0]});
            @(negedge clk);
            membuscmd.mem_read = 1'b0;
         end
      join
      void'(q.pop_front());
      q.push_back(b);
      check_status("pushpop full");
      bus_address = 2'd0;
      membuscmd.mem_read = 1'b1;
      #1 check("pushpop order", membusres.read_data, {1'b1, 23'd0, q[0]});
      void'(q.pop_front());
      @(negedge clk);
      membuscmd.mem_read = 1'b0;
      @(negedge clk);
      b = 8'($urandom);
      fork
         send_frame(b, 1'b1, ^b, 0);
         begin
            repeat (PUSH_AT - 1) @(negedge clk);
            bus_write(2'd2, 32'h8, 4'h1);
         end
      join
      q.delete();
      check_status("flush push");

      for (int r = 0; r < 4; r++) begin
         k = $urandom_range(1, 11);
         for (int j = 0; j < k; j++) begin
            b = 8'($urandom);
            sb = $urandom_range(0, 9) != 0;
            send_frame(b, sb, ^b, 0);
            if (sb) model_push(b);
            else ferr = 1'b1;
         end
         check_status($sformatf("rand%0d status", r));
         drain($sformatf("rand%0d data", r));
         bus_write(2'd2, 32'h3, 4'h1);
         ovr = 1'b0;
         ferr = 1'b0;
         check_status($sformatf("rand%0d clear", r));
      end

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0, 0);
      perr = 1'b1;
      check_status("parity bad");
      send_frame(8'h07, 1'b1, 1'b1, 0);
      model_push(8'h07);
      check_status("parity good");
      bus_write(2'd2, 32'h4, 4'h1);
      perr = 1'b0;
      check_status("parity clear");
      drain("parity data");
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
